// File: rtl/conv_accumulator.sv
// conv_accumulator
//   Sums Taps consecutive valid MAC results into one output pixel, then
//   rounds (half up), arithmetic-shifts by FracShift and saturates to a
//   signed OutWidth value. Results are queued in a first-word-fall-through
//   FIFO with a ready/valid output; Stall warns the feeder before the FIFO
//   fills.
//
//   Optional feature: define CONV_ACC_RELU_EN to clamp negative saturated
//   results to 0 in the post stage.
//
// Ports
//   clk       in   clock, rising edge
//   aclr      in   synchronous active-high reset
//   ValidIn   in   MAC result valid
//   DataIn    in   signed MAC result [DataWidth]
//   OutReady  in   consumer accepts OutData
//   OutValid  out  FIFO non-empty
//   OutData   out  FIFO head [OutWidth], 0 when empty
//   Stall     out  FIFO occupancy >= FifoDepth - StallMargin
//   Overflow  out  sticky: a result was dropped on a full FIFO
//   TapCount  out  index of the next tap
module conv_accumulator #(
   parameter int DataWidth   = 32,
   parameter int AccWidth    = 40,
   parameter int Taps        = 9,
   parameter int FracShift   = 8,
   parameter int OutWidth    = 16,
   parameter int FifoDepth   = 8,
   parameter int StallMargin = 3
) (
   input  logic                                        clk,
   input  logic                                        aclr,
   input  logic                                        ValidIn,
   input  logic [DataWidth-1:0]                        DataIn,
   input  logic                                        OutReady,
   output logic                                        OutValid,
   output logic [OutWidth-1:0]                         OutData,
   output logic                                        Stall,
   output logic                                        Overflow,
   output logic [((Taps > 1) ? $clog2(Taps) : 1)-1:0]  TapCount
);

   localparam int TW = (Taps > 1) ? $clog2(Taps) : 1;
   localparam int AW = $clog2(FifoDepth);
   // One extra bit so the rounding add cannot wrap past the top of Acc.
   localparam int RW = AccWidth + 1;

   // Rounding term is 2^(FracShift-1), or 0 when FracShift is 0.
   localparam logic signed [RW-1:0] RND  = signed'((RW'(1) << FracShift) >> 1);
   localparam logic signed [RW-1:0] SMAX = signed'((RW'(1) << (OutWidth - 1)) - RW'(1));
   localparam logic signed [RW-1:0] SMIN = -SMAX - signed'(RW'(1));

   // ---------------- stage 1: tap counter and accumulator ----------------
   logic [TW-1:0]       tap;
   logic [AccWidth-1:0] acc;
   logic [AccWidth-1:0] ext;
   logic                last_tap;
   logic                done;

   assign ext      = {{(AccWidth - DataWidth){DataIn[DataWidth-1]}}, DataIn};
   assign last_tap = (tap == TW'(Taps - 1));
   assign TapCount = tap;

   always_ff @(posedge clk) begin
      if (aclr) begin
         tap  <= '0;
         acc  <= '0;
         done <= 1'b0;
      end else begin
         done <= ValidIn && last_tap;
         if (ValidIn) begin
            acc <= (tap == '0) ? ext : acc + ext;
            tap <= last_tap ? '0 : tap + TW'(1);
         end
      end
   end

   // ---------------- stage 2: round, shift, saturate ----------------
   logic signed [RW-1:0] wide;
   logic signed [RW-1:0] shf;
   logic [OutWidth-1:0]  sat;
   logic [OutWidth-1:0]  post_res;
   logic                 post_valid;
   logic [OutWidth-1:0]  post_data;

   always_comb begin
      wide = signed'({acc[AccWidth-1], acc}) + RND;
      shf  = wide >>> FracShift;
      if (shf > SMAX)
         sat = SMAX[OutWidth-1:0];
      else if (shf < SMIN)
         sat = SMIN[OutWidth-1:0];
      else
         sat = shf[OutWidth-1:0];
`ifdef CONV_ACC_RELU_EN
      post_res = sat[OutWidth-1] ? '0 : sat;
`else
      post_res = sat;
`endif
   end

   // Acc may already hold the next pixel's tap 0 here; the non-blocking
   // update means stage 2 still sees the completed sum on this edge.
   always_ff @(posedge clk) begin
      if (aclr) begin
         post_valid <= 1'b0;
         post_data  <= '0;
      end else begin
         post_valid <= done;
         if (done)
            post_data <= post_res;
      end
   end

   // ---------------- result FIFO ----------------
   logic [OutWidth-1:0] mem [FifoDepth];
   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;
   logic [AW:0]         count;
   logic                full;
   logic                pop;
   logic                push_ok;
   logic                ovf;

   assign full     = (count == (AW + 1)'(FifoDepth));
   assign OutValid = (count != '0);
   assign pop      = OutValid && OutReady;
   // A pop on the same edge frees the slot, so a push on full is accepted.
   assign push_ok  = post_valid && (!full || pop);
   assign OutData  = OutValid ? mem[rptr] : '0;
   assign Stall    = (count >= (AW + 1)'(FifoDepth - StallMargin));
   assign Overflow = ovf;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr] <= post_data;
   end

   always_ff @(posedge clk) begin
      if (aclr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push_ok)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (post_valid && !push_ok)
            ovf <= 1'b1;
      end
   end

endmodule
